// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding and BCD digit-adjust constants for bin2bcd_seq
package bin2bcd_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD = 3;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/valid conversion handshake; ovf member present only with BIN2BCD_OVF_EN
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(parameter int WIDTH = 6, parameter int DIGITS = 2);
  logic start;
  logic [WIDTH-1:0] in;
  logic ready;
  logic valid;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
`ifdef BIN2BCD_OVF_EN
  logic ovf;
  modport master (output start, in, input ready, valid, bcd, ovf);
  modport slave (input start, in, output ready, valid, bcd, ovf);
`else
  modport master (output start, in, input ready, valid, bcd);
  modport slave (input start, in, output ready, valid, bcd);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational double-dabble cell, adds 3 to a BCD digit of 5 or more
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  assign q = (d >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? d + BCD_DIGIT_W'(BCD_ADJ_ADD) : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD, one iteration per clock; saturation via BIN2BCD_OVF_EN
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIGITS = 2
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_seq_if.slave bus
);
  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sr, sr_nx;
  logic [BW-1:0] adj, bcd_q;
  logic valid_q, accept, done;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(sr[WIDTH+BCD_DIGIT_W*g +: BCD_DIGIT_W]), .q(adj[BCD_DIGIT_W*g +: BCD_DIGIT_W]));
  end
  assign sr_nx = {adj, sr[WIDTH-1:0]} << 1;
  assign accept = state == IDLE && bus.start;
  assign done = state == SHIFT && cnt == CW'(1);
  assign bus.ready = state == IDLE;
  assign bus.valid = valid_q;
  assign bus.bcd = bcd_q;
  // next state: leave IDLE on start, return once the last iteration completes
  always_comb begin
    state_nx = (state == IDLE) ? (bus.start ? SHIFT : IDLE) : (done ? IDLE : SHIFT);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
`ifdef BIN2BCD_OVF_EN
  localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);
  logic ovf_pending, ovf_q;
  assign bus.ovf = ovf_q;
  // capture out-of-range at acceptance; publish saturation flag alongside valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pending <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) ovf_pending <= 32'(bus.in) > MAXV;
      if (done) ovf_q <= ovf_pending;
    end
  end
`else
  localparam logic ovf_pending = 1'b0;
`endif
  // datapath: load operand, iterate adjust+shift, publish result on the final iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr <= '0;
      valid_q <= 1'b0;
      bcd_q <= '0;
    end else begin
      valid_q <= done;
      if (accept) begin
        sr <= {{BW{1'b0}}, bus.in};
        cnt <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        sr <= sr_nx;
        cnt <= cnt - CW'(1);
      end
      if (done) bcd_q <= ovf_pending ? {DIGITS{4'h9}} : sr_nx[SW-1 -: BW];
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq at (6,2), (8,2) and (1,1); ovf checks with BIN2BCD_OVF_EN
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  bin2bcd_seq_if #(.WIDTH(6), .DIGITS(2)) a ();
  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(2)) b ();
  bin2bcd_seq_if #(.WIDTH(1), .DIGITS(1)) c ();
  bin2bcd_seq #(.WIDTH(6), .DIGITS(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  bin2bcd_seq #(.WIDTH(1), .DIGITS(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c.slave));
  typedef struct {
    logic [7:0] v;
    logic [7:0] e;
  } vec_a_t;
  typedef struct {
    logic [7:0] v;
    logic [7:0] e_sat;
    logic [7:0] e_mod;
    logic       o;
  } vec_b_t;
  typedef struct {
    logic [7:0] e;
    logic       o;
  } exp_b_t;
  logic [7:0] qa[$];
  exp_b_t     qb[$];
  logic [3:0] qc[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic unexpected(input string n);
    checks++;
    errors++;
    $display("FAIL %s unexpected valid", n);
  endtask
  always @(negedge clk) if (a.valid === 1'b1) begin
    if (qa.size() == 0) unexpected("a");
    else chk("a_bcd", 32'(a.bcd), 32'(qa.pop_front()));
`ifdef BIN2BCD_OVF_EN
    chk("a_ovf", 32'(a.ovf), 32'(0));
`endif
  end
  always @(negedge clk) if (b.valid === 1'b1) begin
    if (qb.size() == 0) unexpected("b");
    else begin
      exp_b_t x;
      x = qb.pop_front();
      chk("b_bcd", 32'(b.bcd), 32'(x.e));
`ifdef BIN2BCD_OVF_EN
      chk("b_ovf", 32'(b.ovf), 32'(x.o));
`endif
    end
  end
  always @(negedge clk) if (c.valid === 1'b1) begin
    if (qc.size() == 0) unexpected("c");
    else chk("c_bcd", 32'(c.bcd), 32'(qc.pop_front()));
  end
  task automatic wait_ready(input string n, input logic r);
    int k = 0;
    while (r !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s ready timeout got 0 expected 1", n);
    end
  endtask
  task automatic send_a(input logic [5:0] v, input logic [7:0] e);
    int k = 0;
    while (!a.ready && k < 100) begin @(negedge clk); k++; end
    a.start = 1'b1;
    a.in = v;
    qa.push_back(e);
    @(negedge clk);
    a.start = 1'b0;
    a.in = 6'($urandom);
  endtask
  task automatic send_b(input logic [7:0] v, input logic [7:0] e, input logic o);
    int k = 0;
    exp_b_t x;
    while (!b.ready && k < 100) begin @(negedge clk); k++; end
    x.e = e;
    x.o = o;
    b.start = 1'b1;
    b.in = v;
    qb.push_back(x);
    @(negedge clk);
    b.start = 1'b0;
    b.in = 8'($urandom);
  endtask
  task automatic drain();
    int k = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain timeout pending %0d expected 0", qa.size() + qb.size() + qc.size());
      qa.delete();
      qb.delete();
      qc.delete();
    end
    repeat (10) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_a_t va[10];
    vec_b_t vb[6];
    int n;
    va = '{'{8'd63, 8'h63}, '{8'd0, 8'h00}, '{8'd9, 8'h09}, '{8'd42, 8'h42}, '{8'd10, 8'h10},
           '{8'd59, 8'h59}, '{8'd1, 8'h01}, '{8'd50, 8'h50}, '{8'd37, 8'h37}, '{8'd19, 8'h19}};
    vb = '{'{8'd200, 8'h99, 8'h00, 1'b1}, '{8'd99, 8'h99, 8'h99, 1'b0}, '{8'd255, 8'h99, 8'h55, 1'b1},
           '{8'd100, 8'h99, 8'h00, 1'b1}, '{8'd0, 8'h00, 8'h00, 1'b0}, '{8'd187, 8'h99, 8'h87, 1'b1}};
    a.start = 1'b0; a.in = '0;
    b.start = 1'b0; b.in = '0;
    c.start = 1'b0; c.in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(a.ready), 32'(1));
    chk("rst_valid", 32'(a.valid), 32'(0));
    chk("rst_bcd", 32'(a.bcd), 32'(0));
    chk("rst_b_bcd", 32'(b.bcd), 32'(0));
`ifdef BIN2BCD_OVF_EN
    chk("rst_ovf", 32'(b.ovf), 32'(0));
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(a.ready), 32'(1));
    chk("post_rst_valid", 32'(a.valid), 32'(0));
    // latency: ready low for WIDTH cycles, then one-cycle valid
    a.start = 1'b1;
    a.in = 6'd63;
    qa.push_back(8'h63);
    @(negedge clk);
    a.start = 1'b0;
    a.in = 6'd5;
    for (int i = 0; i < 6; i++) begin
      chk("lat_ready_low", 32'(a.ready), 32'(0));
      chk("lat_no_valid", 32'(a.valid), 32'(0));
      @(negedge clk);
    end
    chk("lat_valid", 32'(a.valid), 32'(1));
    chk("lat_ready_back", 32'(a.ready), 32'(1));
    @(negedge clk);
    chk("lat_valid_pulse", 32'(a.valid), 32'(0));
    chk("lat_bcd_hold", 32'(a.bcd), 32'(8'h63));
    drain();
    for (int i = 0; i < 10; i++) begin
      send_a(va[i].v[5:0], va[i].e);
      drain();
    end
    // start during SHIFT is ignored
    send_a(6'd42, 8'h42);
    @(negedge clk);
    a.start = 1'b1;
    a.in = 6'd17;
    @(negedge clk);
    a.start = 1'b0;
    drain();
    // back-to-back with start held high
    a.start = 1'b1;
    a.in = 6'd10;
    qa.push_back(8'h10);
    @(negedge clk);
    a.in = 6'd59;
    qa.push_back(8'h59);
    n = 0;
    while (a.valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("b2b_first", 32'(n), 32'(6));
    @(negedge clk);
    a.start = 1'b0;
    n = 1;
    while (a.valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("b2b_gap", 32'(n), 32'(7));
    drain();
    // reset in the middle of a conversion
    a.start = 1'b1;
    a.in = 6'd37;
    @(negedge clk);
    a.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(a.ready), 32'(1));
    chk("midrst_valid", 32'(a.valid), 32'(0));
    chk("midrst_bcd", 32'(a.bcd), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_idle", 32'(a.ready), 32'(1));
    chk("midrst_bcd_hold", 32'(a.bcd), 32'(0));
    for (int i = 0; i < 6; i++) begin
`ifdef BIN2BCD_OVF_EN
      send_b(vb[i].v, vb[i].e_sat, vb[i].o);
`else
      send_b(vb[i].v, vb[i].e_mod, 1'b0);
`endif
      drain();
    end
    // WIDTH=1: result one iteration after acceptance
    wait_ready("c", c.ready);
    c.start = 1'b1;
    c.in = 1'b1;
    qc.push_back(4'h1);
    @(negedge clk);
    c.start = 1'b0;
    c.in = 1'b0;
    chk("w1_busy", 32'(c.ready), 32'(0));
    @(negedge clk);
    chk("w1_valid", 32'(c.valid), 32'(1));
    drain();
    c.start = 1'b1;
    c.in = 1'b0;
    qc.push_back(4'h0);
    @(negedge clk);
    c.start = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
